ah_wrr_arbiter: RTL and testbench
=================================

# ah_wrr_arbiter

Parametrised weighted round-robin arbiter with grant tenure, lock and zero-bubble handover, replacing the fixed-width 32-way round-robin arbiters. Sits in front of a shared resource (bus port, memory bank, output queue); each requester holds a registered one-hot grant for up to its programmed weight in beats before priority rotates. Grant is registered, never combinational from `req`.

## Interface
- `N`, default 8: number of requesters, legal 2..64.
- `WW`, default 4: weight field width per requester.
- `IW`, default $clog2(N): grant index width (derived, not overridden).

- `clk`  in  1  clock, all logic on rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `req`  in  N  per-requester request level; one beat consumed per cycle while granted and high.
- `weight`  in  N*WW  requester i weight at [i*WW +: WW]; 0 treated as 1.
- `lock`  in  N  lock[i] high while i is owner suppresses credit expiry.
- `grant`  out  N  registered one-hot grant, all zero when idle.
- `grant_vld`  out  1  OR of `grant`.
- `grant_id`  out  IW  binary index of owner; 0 when idle.

## Operation
- State: `owner` (IW), `busy` (1), `ptr` (IW, next search start), `credit` (WW+1).
- IDLE (`busy`=0): pick first `req[i]` high searching from `ptr` upward, wrapping modulo N. If found: `busy`←1, `owner`←i, `credit`←max(weight[i],1), `ptr`←(i+1) mod N. Else stay IDLE.
- GRANT (`busy`=1, owner k), per cycle:
  - `req[k]`=0: release, no beat consumed.
  - `req[k]`=1, `lock[k]`=1: beat consumed, `credit` held (never below 1).
  - `req[k]`=1, `lock[k]`=0, `credit`>1: beat consumed, `credit`−1.
  - `req[k]`=1, `lock[k]`=0, `credit`=1: last beat, release.
- Release: same-cycle re-arbitration from (k+1) mod N, wrapping, k searched last. Winner loaded exactly as from IDLE; no winner → IDLE. No bubble between owners.
- Sole requester k at expiry is re-granted with fresh credit; `grant` stays high continuously.
- `weight` sampled only at grant load; mid-tenure changes take effect at next grant.
- Credit arithmetic in WW+1 bits; weight all-ones (15 at WW=4) gives 15 beats, no overflow.
- `lock` on a non-owner is ignored; lock does not keep a grant when `req[k]` drops.

## Timing
- Reset (async assert, sync-deassert expected upstream): `grant`=0, `grant_vld`=0, `grant_id`=0, `ptr`=0, `credit`=0, `busy`=0.
- Latency: `req` rising at cycle t from IDLE → `grant` at t+1.
- Handover: last beat of owner at cycle t → new owner's `grant` at t+1; old owner's `grant` low at t+1.
- `grant`, `grant_vld`, `grant_id` all from flops, mutually consistent every cycle.
- Reset mid-tenure: outputs clear immediately; after release, first grant searches from index 0.

## Structure
- Package `ah_arb_pkg`: default `N`/`WW` constants, `ah_clog2` function, onehot-to-index function shared with other arbiters.
- Sub-module `ah_rr_pick`: combinational rotate-priority picker (`req`, `start` → one-hot `pick`, `pick_id`, `pick_vld`); parametrised on N, reusable by future arbiters.
- Top holds state registers, credit logic, output flops.

## Test plan
- Reset: hold `rstn`=0 with `req`=8'hFF → all outputs 0; release, next cycle `grant`=8'h01, `grant_id`=0.
- Weighted rotation: N=8, weights {1,2,3,0,...}, `req`=8'h07 constant → grant pattern 0,1,1,2,2,2,0,1,1,… with no idle cycles.
- Early release: owner 2 weight 5, drop `req[2]` after 2 beats with `req[5]` high → `grant`=8'h20 the following cycle, `ptr`→6.
- Lock: owner 3 weight 1, `lock[3]`=1 for 10 cycles with `req`=8'h18 → grant[3] held 10+ cycles; after lock drops, one beat then grant moves to 4.
- Sole requester: only `req[6]` high, weight 2, 20 cycles → `grant`=8'h40 continuously, `grant_id`=6.
- Wrap/width: N=64, `req` bits 63 and 0, weights 1 → grants alternate 63,0,63,… ; N=3 non-power-of-two → search never selects index 3.

Source files
------------

// File: rtl/ah_arb_pkg.sv
// Shared arbiter definitions: default sizes, FSM encoding and index helpers.
package ah_arb_pkg;

  localparam int AH_N_DEF  = 8;
  localparam int AH_WW_DEF = 4;
  localparam int AH_MAX_N  = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } ah_arb_st_e;

  function automatic int ah_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // One-hot to binary; OR-reduction form, so a zero vector yields index 0.
  function automatic int ah_oh2idx(input logic [AH_MAX_N-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < AH_MAX_N; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ah_rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or after start,
// wrapping modulo N.
module ah_rr_pick
  import ah_arb_pkg::*;
#(
  parameter int N  = AH_N_DEF,
  parameter int IW = ah_clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_id,
  output logic          pick_vld
);

  logic [AH_MAX_N-1:0] pick_ext;

  always_comb begin
    int            s;
    int            idx;
    logic [IW-1:0] ix;
    logic          found;
    pick  = '0;
    found = 1'b0;
    s     = (int'(start) < N) ? int'(start) : 0;
    for (int off = 0; off < N; off++) begin
      idx = s + off;
      if (idx >= N) idx = idx - N;
      ix = IW'(idx);
      if (!found && req[ix]) begin
        pick[ix] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    pick_ext        = '0;
    pick_ext[N-1:0] = pick;
  end

  assign pick_id  = IW'(ah_oh2idx(pick_ext));
  assign pick_vld = |pick;

endmodule

// File: rtl/ah_wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant held for up to the
// owner's weight in beats, lock extends tenure, zero-bubble handover.
module ah_wrr_arbiter
  import ah_arb_pkg::*;
#(
  parameter int N  = AH_N_DEF,
  parameter int WW = AH_WW_DEF,
  parameter int IW = ah_clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic [N*WW-1:0] weight,
  input  logic [N-1:0]  lock,
  output logic [N-1:0]  grant,
  output logic          grant_vld,
  output logic [IW-1:0] grant_id
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [WW:0]   ONE  = (WW + 1)'(1);

  ah_arb_st_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [WW:0]   credit_q, credit_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          vld_q, vld_d;

  logic          busy, own_req, own_lock, release_w, arb_en;
  logic [IW-1:0] start;
  logic [N-1:0]  pick;
  logic [IW-1:0] pick_id;
  logic          pick_vld;
  logic [WW-1:0] pick_w;
  logic [WW:0]   load_credit;

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] x);
    return (x == LAST) ? '0 : x + IW'(1);
  endfunction

  assign busy      = (state_q == ST_GRANT);
  assign own_req   = req[owner_q];
  assign own_lock  = lock[owner_q];
  assign release_w = busy && (!own_req || (!own_lock && credit_q == ONE));
  assign arb_en    = !busy || release_w;
  // On release the search starts just past the owner, so the owner is tried last.
  assign start     = busy ? inc_mod(owner_q) : ptr_q;

  ah_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req      (req),
    .start    (start),
    .pick     (pick),
    .pick_id  (pick_id),
    .pick_vld (pick_vld)
  );

  always_comb begin
    pick_w = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_w = pick_w | weight[i*WW +: WW];
    end
  end

  assign load_credit = (pick_w == '0) ? ONE : {1'b0, pick_w};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    grant_d  = grant_q;
    vld_d    = vld_q;
    if (arb_en) begin
      if (pick_vld) begin
        state_d  = ST_GRANT;
        owner_d  = pick_id;
        ptr_d    = inc_mod(pick_id);
        credit_d = load_credit;
        grant_d  = pick;
        vld_d    = 1'b1;
      end else begin
        state_d  = ST_IDLE;
        owner_d  = '0;
        credit_d = '0;
        grant_d  = '0;
        vld_d    = 1'b0;
      end
    end else if (!own_lock) begin
      credit_d = credit_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_q  <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
      grant_q  <= '0;
      vld_q    <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      grant_q  <= grant_d;
      vld_q    <= vld_d;
    end
  end

  assign grant     = grant_q;
  assign grant_vld = vld_q;
  assign grant_id  = owner_q;

endmodule

// File: tb/tb_ah_wrr_arbiter.sv
// Directed bench for ah_wrr_arbiter at N=8, N=64 and N=3.
module tb_ah_wrr_arbiter;

  logic clk;
  logic rstn;

  logic [7:0]   req8, lock8, g8;
  logic [31:0]  w8;
  logic         v8;
  logic [2:0]   id8;

  logic [63:0]  req64, lock64, g64;
  logic [255:0] w64;
  logic         v64;
  logic [5:0]   id64;

  logic [2:0]   req3, lock3, g3;
  logic [11:0]  w3;
  logic         v3;
  logic [1:0]   id3;

  int checks;
  int failures;

  ah_wrr_arbiter #(.N(8), .WW(4)) u8 (
    .clk(clk), .rstn(rstn), .req(req8), .weight(w8), .lock(lock8),
    .grant(g8), .grant_vld(v8), .grant_id(id8)
  );

  ah_wrr_arbiter #(.N(64), .WW(4)) u64 (
    .clk(clk), .rstn(rstn), .req(req64), .weight(w64), .lock(lock64),
    .grant(g64), .grant_vld(v64), .grant_id(id64)
  );

  ah_wrr_arbiter #(.N(3), .WW(4)) u3 (
    .clk(clk), .rstn(rstn), .req(req3), .weight(w3), .lock(lock3),
    .grant(g3), .grant_vld(v3), .grant_id(id3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_idle();
    rstn   = 1'b0;
    req8   = '0;
    lock8  = '0;
    req64  = '0;
    req3   = '0;
    tick();
    rstn   = 1'b1;
  endtask

  initial begin
    int exp2 [9] = '{0, 1, 1, 2, 2, 2, 0, 1, 1};
    int exp6 [4] = '{0, 63, 0, 63};
    int exp7 [5] = '{0, 1, 2, 0, 1};
    logic [7:0]  oh8;
    logic [63:0] oh64;
    logic [2:0]  oh3;

    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    req8     = 8'hFF;
    lock8    = '0;
    w8       = '0;
    req64    = '0;
    lock64   = '0;
    w64      = '0;
    req3     = '0;
    lock3    = '0;
    w3       = '0;

    // Reset held with all requests high
    repeat (3) tick();
    chk("rst_grant", 64'(g8), 64'h0);
    chk("rst_vld", 64'(v8), 64'h0);
    chk("rst_id", 64'(id8), 64'h0);
    chk("rst_g64", g64, 64'h0);
    rstn = 1'b1;
    tick();
    chk("first_grant", 64'(g8), 64'h01);
    chk("first_id", 64'(id8), 64'h0);
    chk("first_vld", 64'(v8), 64'h1);
    tick();
    chk("second_grant", 64'(g8), 64'h02);
    chk("second_id", 64'(id8), 64'h1);

    // Asynchronous reset mid-tenure, then search restarts at index 0
    rstn = 1'b0;
    #1;
    chk("midrst_grant", 64'(g8), 64'h0);
    chk("midrst_vld", 64'(v8), 64'h0);
    chk("midrst_id", 64'(id8), 64'h0);
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_grant", 64'(g8), 64'h01);

    // Weighted rotation: weights {1,2,3,0,...}
    w8 = '0;
    w8[3:0]  = 4'd1;
    w8[7:4]  = 4'd2;
    w8[11:8] = 4'd3;
    reset_idle();
    req8 = 8'h07;
    for (int i = 0; i < 9; i++) begin
      tick();
      oh8 = 8'd1 << exp2[i];
      chk("wrr_id", 64'(id8), 64'(exp2[i]));
      chk("wrr_grant", 64'(g8), 64'(oh8));
    end

    // Early release of owner 2 hands over to 5, pointer then sits at 6
    w8 = '0;
    w8[11:8] = 4'd5;
    reset_idle();
    req8 = 8'h24;
    tick();
    chk("early_own2", 64'(g8), 64'h04);
    tick();
    tick();
    chk("early_hold2", 64'(g8), 64'h04);
    req8 = 8'h20;
    tick();
    chk("early_to5", 64'(g8), 64'h20);
    chk("early_id5", 64'(id8), 64'h5);
    req8 = 8'h00;
    tick();
    chk("early_idle", 64'(g8), 64'h0);
    chk("early_idle_vld", 64'(v8), 64'h0);
    req8 = 8'h41;
    tick();
    chk("early_ptr6", 64'(g8), 64'h40);

    // Lock extends owner 3 beyond weight 1
    w8 = '0;
    reset_idle();
    req8  = 8'h18;
    lock8 = 8'h08;
    tick();
    chk("lock_first", 64'(g8), 64'h08);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("lock_hold", 64'(g8), 64'h08);
    end
    lock8 = 8'h00;
    tick();
    chk("lock_release", 64'(g8), 64'h10);

    // Sole requester re-granted without a gap
    w8 = '0;
    w8[27:24] = 4'd2;
    reset_idle();
    req8 = 8'h40;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sole_grant", 64'(g8), 64'h40);
      chk("sole_id", 64'(id8), 64'h6);
    end

    // Full-scale weight 15 on requester 1, zero weight on 0 acts as 1
    w8 = '0;
    w8[7:4] = 4'hF;
    reset_idle();
    req8 = 8'h02;
    tick();
    chk("w15_start", 64'(id8), 64'h1);
    req8 = 8'h03;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("w15_hold", 64'(g8), 64'h02);
    end
    tick();
    chk("w15_handover", 64'(g8), 64'h01);
    tick();
    chk("w0_one_beat", 64'(g8), 64'h02);

    // N=64: wrap between 63 and 0
    reset_idle();
    req64[63] = 1'b1;
    req64[0]  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      oh64 = 64'd1 << exp6[i];
      chk("n64_id", 64'(id64), 64'(exp6[i]));
      chk("n64_grant", g64, oh64);
    end

    // N=3: non-power-of-two wrap
    reset_idle();
    req3 = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick();
      oh3 = 3'd1 << exp7[i];
      chk("n3_id", 64'(id3), 64'(exp7[i]));
      chk("n3_grant", 64'(g3), 64'(oh3));
    end
    req3 = 3'b100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("n3_sole_id", 64'(id3), 64'h2);
      chk("n3_sole_vld", 64'(v3), 64'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
